// File: rtl/mult_control_pkg.sv
// ---------------------------------------------------------------------------
// mult_control_pkg
// Shared definitions for the shift-add multiplier controller: default
// operand/counter widths, FSM state encoding, datapath select encodings
// and a helper that maps a state onto its Moore output values.
// No ports (package).
// ---------------------------------------------------------------------------
package mult_control_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // a_sel / b_sel: pick fresh operand or the shifted register value
  localparam logic SEL_LOAD  = 1'b0;
  localparam logic SEL_SHIFT = 1'b1;
  // prod_sel: clear the product or take the add mux output
  localparam logic PROD_CLR  = 1'b0;
  localparam logic PROD_TAKE = 1'b1;
  // add_sel: keep the product or accumulate A
  localparam logic ADD_HOLD  = 1'b0;
  localparam logic ADD_SUM   = 1'b1;

  typedef struct packed {
    logic aSel;
    logic bSel;
    logic prodSel;
    logic busy;
    logic done;
  } ctrl_outs_t;

  // Moore output values for each state. add_sel is not in here because in
  // CALC it follows b_lsb combinationally and is 0 everywhere else.
  function automatic ctrl_outs_t stateOutputs(input state_e s);
    ctrl_outs_t o;
    o = '{aSel: SEL_LOAD, bSel: SEL_LOAD, prodSel: PROD_TAKE, busy: 1'b0, done: 1'b0};
    case (s)
      ST_LOAD: o = '{aSel: SEL_LOAD,  bSel: SEL_LOAD,  prodSel: PROD_CLR,  busy: 1'b1, done: 1'b0};
      ST_CALC: o = '{aSel: SEL_SHIFT, bSel: SEL_SHIFT, prodSel: PROD_TAKE, busy: 1'b1, done: 1'b0};
      ST_DONE: o = '{aSel: SEL_SHIFT, bSel: SEL_SHIFT, prodSel: PROD_TAKE, busy: 1'b0, done: 1'b1};
      default: o = '{aSel: SEL_LOAD,  bSel: SEL_LOAD,  prodSel: PROD_TAKE, busy: 1'b0, done: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mult_control_if.sv
// ---------------------------------------------------------------------------
// mult_control_if
// Bundles the controller's handshake and datapath-control signals.
//   start    parent -> ctrl   request a multiply (sampled in IDLE)
//   b_lsb    datapath -> ctrl LSB of the B register
//   b_zero   datapath -> ctrl B register is zero
//   a_sel    ctrl -> datapath 0 load a, 1 A<<1
//   b_sel    ctrl -> datapath 0 load b, 1 B>>1
//   prod_sel ctrl -> datapath 0 clear product, 1 take add mux
//   add_sel  ctrl -> datapath 0 hold product, 1 product + A
//   busy     ctrl -> parent   high in LOAD and CALC
//   done     ctrl -> parent   one-cycle pulse, product valid
// modport slave is the controller; modport master is the parent/datapath.
// ---------------------------------------------------------------------------
interface mult_control_if;

  logic start;
  logic b_lsb;
  logic b_zero;
  logic a_sel;
  logic b_sel;
  logic prod_sel;
  logic add_sel;
  logic busy;
  logic done;

  modport master (
    output start, b_lsb, b_zero,
    input  a_sel, b_sel, prod_sel, add_sel, busy, done
  );

  modport slave (
    input  start, b_lsb, b_zero,
    output a_sel, b_sel, prod_sel, add_sel, busy, done
  );

endinterface

// File: rtl/mult_control_iter_counter.sv
// ---------------------------------------------------------------------------
// mult_iter_counter
// Counts CALC iterations of the multiplier controller.
//   clk      in  rising-edge clock
//   reset    in  synchronous active-high reset
//   clr      in  force the count to zero (LOAD)
//   en       in  advance the count (CALC)
//   terminal out count == WIDTH-1, i.e. this is the last iteration
// The count wraps back to zero after the terminal value, so it never
// leaves the range 0..WIDTH-1.
// ---------------------------------------------------------------------------
module mult_iter_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic terminal
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign terminal = (cnt_q == CNT_W'(WIDTH - 1));

  // Next count: clear wins over enable; the terminal value rolls over to
  // zero instead of walking past WIDTH-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = terminal ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mult_control.sv
// ---------------------------------------------------------------------------
// mult_control
// Control FSM for a shift-add multiplier datapath: IDLE -> LOAD -> CALC
// (one cycle per multiplier bit) -> DONE -> IDLE.
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset (also clears the datapath)
//   ctrl   mult_control_if.slave: start/b_lsb/b_zero in,
//          a_sel/b_sel/prod_sel/add_sel/busy/done out
// Build option: define MULT_CTRL_EARLY_EXIT_EN to leave CALC as soon as the
// datapath reports B == 0; otherwise exactly WIDTH CALC cycles are run.
// ---------------------------------------------------------------------------
module mult_control
  import mult_control_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  mult_control_if.slave ctrl
);

  state_e     state_q;
  state_e     state_d;
  ctrl_outs_t outs_q;
  logic       iterTerminal;
  logic       cntClr;
  logic       cntEn;
  logic       calcExit;

  assign cntClr = (state_q == ST_LOAD);
  assign cntEn  = (state_q == ST_CALC);

  mult_iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) iterCounter (
    .clk      (clk),
    .reset    (reset),
    .clr      (cntClr),
    .en       (cntEn),
    .terminal (iterTerminal)
  );

`ifdef MULT_CTRL_EARLY_EXIT_EN
  // Once B has shifted out to zero the remaining iterations add nothing,
  // so CALC may finish early.
  assign calcExit = iterTerminal | ctrl.b_zero;
`else
  logic unusedBZero;
  assign unusedBZero = ctrl.b_zero;
  assign calcExit    = iterTerminal;
`endif

  // Next-state logic. start is only looked at in IDLE, so requests made
  // while an operation is in flight are dropped rather than queued. Any
  // encoding outside the four states falls back to IDLE.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = ctrl.start ? ST_LOAD : ST_IDLE;
      ST_LOAD: state_d = ST_CALC;
      ST_CALC: state_d = calcExit ? ST_DONE : ST_CALC;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and Moore outputs are registered together; the outputs are
  // decoded from the next state so they line up with the state they
  // belong to without an extra cycle of delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      outs_q  <= stateOutputs(ST_IDLE);
    end else begin
      state_q <= state_d;
      outs_q  <= stateOutputs(state_d);
    end
  end

  // add_sel is the one Mealy output: in CALC it accumulates A exactly when
  // the current multiplier bit is set.
  assign ctrl.add_sel  = (state_q == ST_CALC) ? ctrl.b_lsb : ADD_HOLD;
  assign ctrl.a_sel    = outs_q.aSel;
  assign ctrl.b_sel    = outs_q.bSel;
  assign ctrl.prod_sel = outs_q.prodSel;
  assign ctrl.busy     = outs_q.busy;
  assign ctrl.done     = outs_q.done;

endmodule

// File: tb/tb_mult_control.sv
// ---------------------------------------------------------------------------
// tb_mult_control
// Directed bench for mult_control driving a small shift-add datapath.
// Cycle 0 is the cycle in which start is presented; the controller samples
// it at the end of that cycle.
// ---------------------------------------------------------------------------
module tb_mult_control;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [63:0] aReg;
  logic [31:0] bReg;
  logic [63:0] prodReg;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  int          firstDone;
  int          doneCount;
  int          busyBad;
  logic [63:0] prodAtDone;
  logic        addSelLog [0:7];

`ifdef MULT_CTRL_EARLY_EXIT_EN
  localparam int D35    = 6;
  localparam int DFFFF  = 19;
  localparam int D76    = 6;
  localparam int P76A   = 2;
  localparam int P76B   = 5;
  localparam int RSTCYC = 4;
  localparam int D41    = 4;
  localparam int D40    = 3;
  localparam int D23    = 5;
`else
  localparam int D35    = 34;
  localparam int DFFFF  = 34;
  localparam int D76    = 34;
  localparam int P76A   = 5;
  localparam int P76B   = 20;
  localparam int RSTCYC = 10;
  localparam int D41    = 34;
  localparam int D40    = 34;
  localparam int D23    = 34;
`endif

  always #5 clk = ~clk;

  mult_control_if bus ();

  mult_control #(
    .WIDTH (32),
    .CNT_W (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  assign bus.b_lsb  = bReg[0];
  assign bus.b_zero = (bReg == 32'd0);

  // Reference shift-add datapath steered by the controller's selects.
  always_ff @(posedge clk) begin
    if (reset) begin
      aReg    <= '0;
      bReg    <= '0;
      prodReg <= '0;
    end else begin
      aReg    <= bus.a_sel ? (aReg << 1) : {32'd0, opA};
      bReg    <= bus.b_sel ? (bReg >> 1) : opB;
      prodReg <= bus.prod_sel ? (bus.add_sel ? prodReg + aReg : prodReg) : 64'd0;
    end
  end

  // Hard stop in case something hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s);
    opA       = a;
    opB       = b;
    bus.start = s;
  endtask

  // Issue one operation in cycle 0 and watch cycles 1..cycles, optionally
  // re-pulsing start in two cycles.
  task automatic runOp(input logic [31:0] a, input logic [31:0] b, input int expDone,
                       input int cycles, input int pulse1, input int pulse2);
    firstDone  = -1;
    doneCount  = 0;
    busyBad    = 0;
    prodAtDone = 'x;
    applyStimulus(a, b, 1'b1);
    for (int c = 1; c <= cycles; c++) begin
      stepCycle();
      bus.start = (c == pulse1) || (c == pulse2);
      if (bus.done === 1'b1) begin
        doneCount++;
        if (firstDone < 0) begin
          firstDone  = c;
          prodAtDone = prodReg;
        end
      end
      if (bus.busy !== ((c >= 1) && (c < expDone))) busyBad++;
      if (c < 8) addSelLog[c] = bus.add_sel;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int idleBusy;
    int idleDone;
    int loadBusy;
    int done2;
    logic [63:0] prod2;
    int lateDone;

    reset = 1'b1;
    applyStimulus(32'd0, 32'd0, 1'b0);
    stepCycle();
    stepCycle();

    checkOutput("reset a_sel",    {63'd0, bus.a_sel},    64'd0);
    checkOutput("reset b_sel",    {63'd0, bus.b_sel},    64'd0);
    checkOutput("reset prod_sel", {63'd0, bus.prod_sel}, 64'd1);
    checkOutput("reset add_sel",  {63'd0, bus.add_sel},  64'd0);
    checkOutput("reset busy",     {63'd0, bus.busy},     64'd0);
    checkOutput("reset done",     {63'd0, bus.done},     64'd0);
    checkOutput("reset prod",     prodReg,               64'd0);

    reset = 1'b0;
    stepCycle();
    stepCycle();

    $display("[TB] a=3 b=5");
    runOp(32'd3, 32'd5, D35, 40, -1, -1);
    checkOutput("3x5 done cycle",  64'(firstDone), 64'(D35));
    checkOutput("3x5 done count",  64'(doneCount), 64'd1);
    checkOutput("3x5 busy window", 64'(busyBad),   64'd0);
    checkOutput("3x5 prod@done",   prodAtDone,     64'd15);
    checkOutput("3x5 prod held",   prodReg,        64'd15);
    checkOutput("3x5 add_sel c2",  {63'd0, addSelLog[2]}, 64'd1);
    checkOutput("3x5 add_sel c3",  {63'd0, addSelLog[3]}, 64'd0);

    $display("[TB] a=ffff b=ffff");
    runOp(32'h0000FFFF, 32'h0000FFFF, DFFFF, 40, -1, -1);
    checkOutput("ffff done cycle", 64'(firstDone), 64'(DFFFF));
    checkOutput("ffff done count", 64'(doneCount), 64'd1);
    checkOutput("ffff prod@done",  prodAtDone,     64'h00000000FFFE0001);

    $display("[TB] a=7 b=6 with start re-pulsed");
    runOp(32'd7, 32'd6, D76, 40, P76A, P76B);
    checkOutput("7x6 done cycle",  64'(firstDone), 64'(D76));
    checkOutput("7x6 done count",  64'(doneCount), 64'd1);
    checkOutput("7x6 busy window", 64'(busyBad),   64'd0);
    checkOutput("7x6 prod@done",   prodAtDone,     64'd42);

    $display("[TB] a=9 b=9 with reset mid-operation");
    applyStimulus(32'd9, 32'd9, 1'b1);
    for (int c = 1; c <= RSTCYC; c++) begin
      stepCycle();
      bus.start = 1'b0;
    end
    checkOutput("9x9 busy before reset", {63'd0, bus.busy}, 64'd1);
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    checkOutput("9x9 rst busy",     {63'd0, bus.busy},     64'd0);
    checkOutput("9x9 rst done",     {63'd0, bus.done},     64'd0);
    checkOutput("9x9 rst prod",     prodReg,               64'd0);
    checkOutput("9x9 rst a_sel",    {63'd0, bus.a_sel},    64'd0);
    checkOutput("9x9 rst prod_sel", {63'd0, bus.prod_sel}, 64'd1);
    checkOutput("9x9 rst add_sel",  {63'd0, bus.add_sel},  64'd0);
    lateDone = 0;
    for (int c = 0; c < 40; c++) begin
      stepCycle();
      if (bus.done === 1'b1 || bus.busy === 1'b1) lateDone++;
    end
    checkOutput("9x9 no done after reset", 64'(lateDone), 64'd0);

    $display("[TB] a=4 b=1 and a=4 b=0");
    runOp(32'd4, 32'd1, D41, 40, -1, -1);
    checkOutput("4x1 done cycle", 64'(firstDone), 64'(D41));
    checkOutput("4x1 prod@done",  prodAtDone,     64'd4);
    runOp(32'd4, 32'd0, D40, 40, -1, -1);
    checkOutput("4x0 done cycle", 64'(firstDone), 64'(D40));
    checkOutput("4x0 prod@done",  prodAtDone,     64'd0);

    $display("[TB] a=2 b=3 with start held high");
    firstDone  = -1;
    done2      = -1;
    doneCount  = 0;
    prodAtDone = 'x;
    prod2      = 'x;
    idleBusy   = -1;
    idleDone   = -1;
    loadBusy   = -1;
    applyStimulus(32'd2, 32'd3, 1'b1);
    for (int c = 1; c <= 2 * D23 + 4; c++) begin
      stepCycle();
      if (c == D23 + 3) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        doneCount++;
        if (firstDone < 0) begin
          firstDone  = c;
          prodAtDone = prodReg;
        end else if (done2 < 0) begin
          done2 = c;
          prod2 = prodReg;
        end
      end
      if (c == D23 + 1) begin
        idleBusy = int'(bus.busy);
        idleDone = int'(bus.done);
      end
      if (c == D23 + 2) loadBusy = int'(bus.busy);
    end
    checkOutput("held first done",  64'(firstDone), 64'(D23));
    checkOutput("held second done", 64'(done2),     64'(2 * D23 + 1));
    checkOutput("held done count",  64'(doneCount), 64'd2);
    checkOutput("held prod 1",      prodAtDone,     64'd6);
    checkOutput("held prod 2",      prod2,          64'd6);
    checkOutput("held idle gap",    64'(idleBusy + idleDone), 64'd0);
    checkOutput("held next load",   64'(loadBusy),  64'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
